// File: rtl/param_counter.sv
// Parameterised up/down counter with prescaler, wrap/saturate/one-shot modes,
// registered terminal-count pulse and sticky one-shot completion flag.
module param_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  logic [WIDTH-1:0]      r_count;
  logic [PRESCALE_W-1:0] r_presc;
  logic                  r_tc;
  logic                  r_done;

  logic [WIDTH-1:0]      w_count_nxt;
  logic [PRESCALE_W-1:0] w_presc_nxt;
  logic                  w_tc_nxt;
  logic                  w_done_nxt;
  logic                  w_tick;
  logic                  w_at_t;
  logic                  w_oneshot;
  logic [WIDTH-1:0]      w_term;
  logic [WIDTH-1:0]      w_step;
  mode_e                 w_mode;

  always_comb begin
    w_mode    = mode_e'(mode);
    w_oneshot = (w_mode == MODE_ONESHOT);
    w_tick    = en && (r_presc == prescale);
    w_term    = dir ? '0 : limit;
    // Up-counts above limit are treated as already terminal.
    w_at_t    = dir ? (r_count == '0) : (r_count >= limit);
    w_step    = dir ? (r_count - 1'b1) : (r_count + 1'b1);

    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done && w_oneshot;

    if (clr) begin
      w_count_nxt = '0;
      w_presc_nxt = '0;
      w_done_nxt  = 1'b0;
    end else if (load) begin
      w_count_nxt = load_val;
      w_presc_nxt = '0;
      w_done_nxt  = 1'b0;
    end else if (en) begin
      w_presc_nxt = w_tick ? '0 : (r_presc + 1'b1);
      if (w_tick && !(w_oneshot && r_done)) begin
        if (!w_at_t) begin
          w_count_nxt = w_step;
          w_tc_nxt    = (w_step == w_term);
          if (w_oneshot && w_tc_nxt)
            w_done_nxt = 1'b1;
        end else begin
          unique case (w_mode)
            MODE_SAT:     w_count_nxt = w_term;
            MODE_ONESHOT: w_count_nxt = r_count;
            default:      w_count_nxt = dir ? limit : '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_presc <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign done  = r_done;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter (WIDTH=8, PRESCALE_W=4) with hand-computed
// expectations checked by immediate assertions.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       tc;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  param_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input int exp_cnt, input int exp_tc, input int exp_done);
    step();
    chk({tag, ".count"}, 32'(count), exp_cnt);
    chk({tag, ".tc"},    32'(tc),    exp_tc);
    chk({tag, ".done"},  32'(done),  exp_done);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; mode = 2'b00; clr = 1'b0; load = 1'b0;
    load_val = 8'h00; limit = 8'd9; prescale = 4'd0;
    #2;
    chk("reset.count", 32'(count), 0);
    chk("reset.tc",    32'(tc),    0);
    chk("reset.done",  32'(done),  0);
    #1 rst_n = 1'b1;

    // Wrap up to 9 with no prescale
    en = 1'b1;
    for (int i = 1; i <= 12; i++)
      step_chk("wrap_up", i % 10, ((i % 10) == 9) ? 1 : 0, 0);

    // Asynchronous reset between edges
    load = 1'b1; load_val = 8'h37; en = 1'b0;
    step_chk("load37", 8'h37, 0, 0);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.count", 32'(count), 0);
    chk("async_rst.tc",    32'(tc),    0);
    chk("async_rst.done",  32'(done),  0);
    #2 rst_n = 1'b1;

    // Prescale by 3 with a mid-period freeze
    prescale = 4'd2; en = 1'b1;
    step_chk("pre_a", 0, 0, 0);
    step_chk("pre_b", 0, 0, 0);
    step_chk("pre_c", 1, 0, 0);
    step_chk("pre_d", 1, 0, 0);
    step_chk("pre_e", 1, 0, 0);
    step_chk("pre_f", 2, 0, 0);
    step_chk("pre_g", 2, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++)
      step_chk("pre_frozen", 2, 0, 0);
    en = 1'b1;
    step_chk("pre_resume_a", 2, 0, 0);
    step_chk("pre_resume_b", 3, 0, 0);

    // Saturate down from 5
    prescale = 4'd0; mode = 2'b01; dir = 1'b1; load = 1'b1; load_val = 8'd5;
    step_chk("sat_load", 5, 0, 0);
    load = 1'b0;
    step_chk("sat4", 4, 0, 0);
    step_chk("sat3", 3, 0, 0);
    step_chk("sat2", 2, 0, 0);
    step_chk("sat1", 1, 0, 0);
    step_chk("sat0a", 0, 1, 0);
    step_chk("sat0b", 0, 0, 0);
    step_chk("sat0c", 0, 0, 0);

    // clr beats load
    clr = 1'b1; load = 1'b1; load_val = 8'hAA;
    step_chk("clr_load", 0, 0, 0);
    clr = 1'b0; load = 1'b0;

    // One-shot up to 3
    mode = 2'b10; dir = 1'b0; limit = 8'd3;
    step_chk("os1", 1, 0, 0);
    step_chk("os2", 2, 0, 0);
    step_chk("os3", 3, 1, 1);
    step_chk("os_hold_a", 3, 0, 1);
    step_chk("os_hold_b", 3, 0, 1);
    load = 1'b1; load_val = 8'd0;
    step_chk("os_reload", 0, 0, 0);
    load = 1'b0;
    step_chk("os_restart1", 1, 0, 0);
    step_chk("os_restart2", 2, 0, 0);
    step_chk("os_restart3", 3, 1, 1);
    mode = 2'b00;
    step_chk("os_modechg", 0, 0, 0);

    // Load coinciding with a tick that would otherwise produce tc
    limit = 8'd1; load = 1'b1; load_val = 8'hAA;
    step_chk("load_tick", 8'hAA, 0, 0);
    load = 1'b0;
    step_chk("above_limit_wrap", 0, 0, 0);

    // limit = 0 stays at 0 without tc
    limit = 8'd0;
    for (int i = 0; i < 3; i++)
      step_chk("limit0", 0, 0, 0);

    // Free-running wrap at full range
    limit = 8'hFF; load = 1'b1; load_val = 8'hFE;
    step_chk("fr_load", 8'hFE, 0, 0);
    load = 1'b0;
    step_chk("fr_ff", 8'hFF, 1, 0);
    step_chk("fr_00", 8'h00, 0, 0);
    step_chk("fr_01", 8'h01, 0, 0);

    // Down wrap reloads limit
    dir = 1'b1; limit = 8'd9; load = 1'b1; load_val = 8'd1;
    step_chk("dw_load", 1, 0, 0);
    load = 1'b0;
    step_chk("dw_0", 0, 1, 0);
    step_chk("dw_9", 9, 0, 0);
    step_chk("dw_8", 8, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
